circuito_detector_param: RTL and testbench

//   Parametrised, registered condition detector over a WIDTH-bit input vector.
//   - Evaluates a selectable reduction per cycle: all-ones, any-one or majority.
//   - Asserts x only after the condition has held for HOLD consecutive enabled cycles.
//   - Emits a one-cycle rise pulse on each new detection.
//   - Building block for debounced multi-input enable/valid logic in the circuit series.
//

---
 rtl/circuito_detector_param.sv | 133 +++++++++++++
 tb/tb_circuito_detector_param.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/circuito_detector_param.sv
// ============================================================================
// Module      : circuito_detector_param
// Description : Registered condition detector over a WIDTH-bit input vector.
//               A selectable reduction (AND-all / OR-any / majority / never)
//               must hold for HOLD consecutive enabled cycles before x is
//               asserted; rise pulses once on each new detection.
//               Optional detection event counter, enabled by the macro
//               DETECT_COUNT_EN (evt_cnt is tied to 0 when it is undefined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module circuito_detector_param #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned HOLD  = 2,
    parameter int unsigned CNTW  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          clr,
    input  logic [WIDTH-1:0]              din,
    input  logic [1:0]                    mode,
    output logic                          x,
    output logic                          rise,
    output logic [$clog2(HOLD+1)-1:0]     run_cnt,
    output logic [CNTW-1:0]               evt_cnt
);

    localparam int unsigned c_run_w = $clog2(HOLD + 1);
    localparam int unsigned c_pop_w = $clog2(WIDTH + 1);
    localparam logic [c_run_w-1:0] c_hold     = c_run_w'(HOLD);
    localparam logic [c_pop_w-1:0] c_half     = c_pop_w'(WIDTH / 2);
    localparam logic [1:0]         c_mode_and = 2'b00;
    localparam logic [1:0]         c_mode_or  = 2'b01;
    localparam logic [1:0]         c_mode_maj = 2'b10;

    logic [WIDTH-1:0]   din_q,  din_d;
    logic [c_run_w-1:0] run_q,  run_d;
    logic               rise_q, rise_d;
    logic [c_pop_w-1:0] ones;
    logic               cond;
    logic [c_run_w-1:0] run_next;

    // Population count of the registered input, used by the majority mode
    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + c_pop_w'(din_q[i]);
        end
    end

    // Condition decode from registered input and the live mode select
    always_comb begin
        cond = 1'b0;
        case (mode)
            c_mode_and: cond = &din_q;
            c_mode_or:  cond = |din_q;
            c_mode_maj: cond = (ones > c_half);
            default:    cond = 1'b0;
        endcase
    end

    // Streak advance: saturate at HOLD, drop to zero on any false condition
    always_comb begin
        run_next = '0;
        if (cond) begin
            run_next = (run_q == c_hold) ? c_hold : run_q + c_run_w'(1);
        end
    end

    // Next-state selection: clear beats enable; disabled cycles hold and kill rise
    always_comb begin
        din_d  = din_q;
        run_d  = run_q;
        rise_d = 1'b0;
        if (clr) begin
            din_d = '0;
            run_d = '0;
        end else if (en) begin
            din_d  = din;
            run_d  = run_next;
            rise_d = (run_next == c_hold) && (run_q != c_hold);
        end
    end

    // Input stage, streak counter and rise pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q  <= '0;
            run_q  <= '0;
            rise_q <= 1'b0;
        end else begin
            din_q  <= din_d;
            run_q  <= run_d;
            rise_q <= rise_d;
        end
    end

    assign x       = (run_q == c_hold);
    assign rise    = rise_q;
    assign run_cnt = run_q;

`ifdef DETECT_COUNT_EN
    logic [CNTW-1:0] evt_q, evt_d;

    // Saturating detection counter, stepped alongside each rise pulse
    always_comb begin
        evt_d = evt_q;
        if (clr) begin
            evt_d = '0;
        end else if (rise_d && (evt_q != {CNTW{1'b1}})) begin
            evt_d = evt_q + CNTW'(1);
        end
    end

    // Detection counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign evt_cnt = evt_q;
`else
    assign evt_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_circuito_detector_param.sv
// ============================================================================
// Module      : tb_circuito_detector_param
// Description : Directed testbench for circuito_detector_param. Instance a is
//               WIDTH=3/HOLD=2/CNTW=8; instance b is WIDTH=1/HOLD=1/CNTW=2 to
//               cover the single-bit, single-cycle-hold and counter-saturation
//               corners. Counter expectations follow DETECT_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_circuito_detector_param;

`ifdef DETECT_COUNT_EN
    localparam bit c_has_cnt = 1'b1;
`else
    localparam bit c_has_cnt = 1'b0;
`endif

    logic       clk;
    logic       rst_n;

    logic       a_en, a_clr, a_x, a_rise;
    logic [2:0] a_din;
    logic [1:0] a_mode, a_run;
    logic [7:0] a_evt;

    logic       b_en, b_clr, b_x, b_rise;
    logic [0:0] b_din;
    logic [1:0] b_mode;
    logic [0:0] b_run;
    logic [1:0] b_evt;

    int tests_run = 0;
    int tests_failed = 0;

    circuito_detector_param #(.WIDTH(3), .HOLD(2), .CNTW(8)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (a_en),
        .clr     (a_clr),
        .din     (a_din),
        .mode    (a_mode),
        .x       (a_x),
        .rise    (a_rise),
        .run_cnt (a_run),
        .evt_cnt (a_evt)
    );

    circuito_detector_param #(.WIDTH(1), .HOLD(1), .CNTW(2)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (b_en),
        .clr     (b_clr),
        .din     (b_din),
        .mode    (b_mode),
        .x       (b_x),
        .rise    (b_rise),
        .run_cnt (b_run),
        .evt_cnt (b_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected counter value given the number of counted detections
    function automatic logic [31:0] ecnt(input int n);
        return c_has_cnt ? 32'(n) : 32'd0;
    endfunction

    initial begin
        rst_n = 1'b0;
        a_en = 1'b0; a_clr = 1'b0; a_din = 3'b000; a_mode = 2'b00;
        b_en = 1'b0; b_clr = 1'b0; b_din = 1'b0;   b_mode = 2'b10;
        #2;
        chk("reset_x",    a_x,    0);
        chk("reset_rise", a_rise, 0);
        chk("reset_run",  a_run,  0);
        chk("reset_evt",  a_evt,  0);
        chk("reset_b_x",  b_x,    0);
        #10;
        rst_n = 1'b1;

        // AND mode, din=111 held
        a_en = 1'b1; a_mode = 2'b00; a_din = 3'b111;
        tick();  chk("and_e1_run", a_run, 0);
                 chk("and_e1_x",   a_x,   0);
        tick();  chk("and_e2_run", a_run, 1);
                 chk("and_e2_x",   a_x,   0);
        tick();  chk("and_e3_run", a_run, 2);
                 chk("and_e3_x",   a_x,   1);
                 chk("and_e3_rise", a_rise, 1);
                 chk("and_e3_evt", a_evt, ecnt(1));
        tick();  chk("and_e4_run", a_run, 2);
                 chk("and_e4_rise", a_rise, 0);
                 chk("and_e4_x",   a_x,   1);
        a_din = 3'b110;
        tick();  chk("and_glitch_sample_x", a_x, 1);
        a_din = 3'b111;
        tick();  chk("and_glitch_drop_x",   a_x, 0);
                 chk("and_glitch_drop_run", a_run, 0);
        tick();  chk("and_redo_run", a_run, 1);
        tick();  chk("and_redo_rise", a_rise, 1);
                 chk("and_redo_evt", a_evt, ecnt(2));

        // Asynchronous reset mid-run
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_x",    a_x,    0);
        chk("arst_rise", a_rise, 0);
        chk("arst_run",  a_run,  0);
        chk("arst_evt",  a_evt,  0);
        #1;
        rst_n = 1'b1;
        tick();  chk("arst_e1_x", a_x, 0);
        tick();  chk("arst_e2_x", a_x, 0);
        tick();  chk("arst_e3_x", a_x, 1);
                 chk("arst_e3_rise", a_rise, 1);
                 chk("arst_e3_evt", a_evt, ecnt(1));

        // Synchronous clear, then majority mode
        a_clr = 1'b1;
        tick();  chk("clr_run", a_run, 0);
                 chk("clr_x",   a_x,   0);
                 chk("clr_evt", a_evt, 0);
        a_clr = 1'b0; a_mode = 2'b10; a_din = 3'b011;
        tick();
        tick();  chk("maj011_run", a_run, 1);
        tick();  chk("maj011_x",   a_x,   1);
        a_din = 3'b001;
        tick();  chk("maj001_lag_x", a_x, 1);
        tick();  chk("maj001_x_a",   a_x, 0);
        tick();  chk("maj001_x_b",   a_x, 0);

        // OR mode: first edge still sees din_q=001 which is true under OR
        a_mode = 2'b01; a_din = 3'b100;
        tick();  chk("or_run", a_run, 1);
        tick();  chk("or_x",   a_x,   1);

        // Never mode
        a_mode = 2'b11; a_din = 3'b111;
        tick();  chk("never_x_a", a_x, 0);
        tick();
        tick();  chk("never_x_b", a_x, 0);
                 chk("never_run", a_run, 0);

        // Enable toggling freezes the streak
        a_clr = 1'b1; a_mode = 2'b00; a_din = 3'b111;
        tick();
        a_clr = 1'b0;
        tick();  chk("en_e1_run", a_run, 0);
        tick();  chk("en_e2_run", a_run, 1);
        a_en = 1'b0;
        tick();  chk("en_off_run",  a_run,  1);
                 chk("en_off_x",    a_x,    0);
                 chk("en_off_rise", a_rise, 0);
        a_en = 1'b1;
        tick();  chk("en_on_x",    a_x,    1);
                 chk("en_on_rise", a_rise, 1);
                 chk("en_on_evt",  a_evt,  ecnt(1));
        a_en = 1'b0;
        tick();  chk("en_kill_rise", a_rise, 0);
                 chk("en_hold_x",    a_x,    1);
                 chk("en_hold_evt",  a_evt,  ecnt(1));
        a_clr = 1'b1;
        tick();  chk("clr_noen_x",   a_x,   0);
                 chk("clr_noen_run", a_run, 0);
                 chk("clr_noen_evt", a_evt, 0);
        a_clr = 1'b0;

        // WIDTH=1, HOLD=1, CNTW=2: five separate detections, counter saturates at 3
        b_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            b_din = 1'b1;
            tick();  chk("b_pre_x", b_x, 0);
            b_din = 1'b0;
            tick();  chk("b_det_x",    b_x,    1);
                     chk("b_det_rise", b_rise, 1);
                     chk("b_det_evt",  b_evt,  ecnt((i > 3) ? 3 : i));
            tick();  chk("b_gap_x",    b_x,    0);
        end
        b_din = 1'b1;
        tick();
        tick();  chk("b_held_x", b_x, 1);
        b_clr = 1'b1; b_en = 1'b0;
        tick();  chk("b_clr_x",   b_x,   0);
                 chk("b_clr_run", b_run, 0);
                 chk("b_clr_evt", b_evt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
